// File: rtl/core_issue_unit_if.sv
// core_issue_unit_if: instruction, register-file and core signals of core_issue_unit.
// master is the issue unit side, slave is the surrounding source, register file and core.
interface core_issue_unit_if #(
    parameter int unsigned RADR_W = 5
);
    logic              I_valid;
    logic              O_ready;
    logic [3:0]        I_opcode;
    logic [RADR_W-1:0] I_rd;
    logic [RADR_W-1:0] I_rs1;
    logic [RADR_W-1:0] I_rs2;
    logic [RADR_W-1:0] I_rs3;
    logic [RADR_W-1:0] O_rf_radrA;
    logic [RADR_W-1:0] O_rf_radrB;
    logic [RADR_W-1:0] O_rf_radrC;
    logic [31:0]       I_rf_rdataA;
    logic [31:0]       I_rf_rdataB;
    logic [31:0]       I_rf_rdataC;
    logic              O_rf_we;
    logic [RADR_W-1:0] O_rf_wadr;
    logic [31:0]       O_rf_wdata;
    logic [31:0]       O_core_dataA;
    logic [31:0]       O_core_dataB;
    logic [31:0]       O_core_dataC;
    logic [3:0]        O_core_opcode;
    logic              O_core_ctrl;
    logic [31:0]       I_core_data;
    logic              I_core_ctrl;
    logic              O_busy;
    logic              O_err;

    modport master (
        input  I_valid, I_opcode, I_rd, I_rs1, I_rs2, I_rs3,
        input  I_rf_rdataA, I_rf_rdataB, I_rf_rdataC, I_core_data, I_core_ctrl,
        output O_ready, O_rf_radrA, O_rf_radrB, O_rf_radrC, O_rf_we, O_rf_wadr, O_rf_wdata,
        output O_core_dataA, O_core_dataB, O_core_dataC, O_core_opcode, O_core_ctrl,
        output O_busy, O_err
    );

    modport slave (
        output I_valid, I_opcode, I_rd, I_rs1, I_rs2, I_rs3,
        output I_rf_rdataA, I_rf_rdataB, I_rf_rdataC, I_core_data, I_core_ctrl,
        input  O_ready, O_rf_radrA, O_rf_radrB, O_rf_radrC, O_rf_we, O_rf_wadr, O_rf_wdata,
        input  O_core_dataA, O_core_dataB, O_core_dataC, O_core_opcode, O_core_ctrl,
        input  O_busy, O_err
    );
endinterface

// File: rtl/core_issue_unit.sv
// core_issue_unit: queues instructions, reads three operands, issues one op at a time to the core
// and writes the result back. Define CORE_ISSUE_PERF_EN to add issue/stall counters.
module core_issue_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned RADR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    core_issue_unit_if.master bus
`ifdef CORE_ISSUE_PERF_EN
    ,
    output logic [31:0]       O_perf_issued,
    output logic [31:0]       O_perf_stall
`endif
);
    localparam int unsigned     PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned     EntW       = 4 + 4 * RADR_W;
    localparam int unsigned     CntW       = $clog2(TIMEOUT + 1);
    localparam logic [PtrW:0]   DepthVal   = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRead    = 3'd1;
    localparam logic [2:0] StCapture = 3'd2;
    localparam logic [2:0] StIssue   = 3'd3;
    localparam logic [2:0] StWait    = 3'd4;
    localparam logic [2:0] StWb      = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [EntW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              push, pop;
    logic [EntW-1:0]   head;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]       data_a_q, data_b_q, data_c_q;
    logic [31:0]       result_q, result_d;
    logic [3:0]        opcode_q;
    logic [RADR_W-1:0] rd_q;
    logic              err_q, err_d;

    assign push = bus.I_valid && bus.O_ready;
    assign pop  = (state_q == StIssue);
    assign head = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.I_opcode, bus.I_rd, bus.I_rs1, bus.I_rs2, bus.I_rs3};
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        result_d   = result_q;
        err_d      = err_q;
        case (state_q)
            StIdle:    if (count_q != '0) state_d = StRead;
            StRead:    state_d = StCapture;
            StCapture: state_d = StIssue;
            StIssue: begin
                if (bus.I_core_ctrl) begin
                    result_d = bus.I_core_data;
                    state_d  = StWb;
                end else begin
                    wait_cnt_d = CntW'(1);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (bus.I_core_ctrl) begin
                    result_d = bus.I_core_data;
                    state_d  = StWb;
                end else if (wait_cnt_q == TimeoutVal) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            data_c_q   <= '0;
            opcode_q   <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            result_q   <= result_d;
            err_q      <= err_d;
            if (state_q == StCapture) begin
                data_a_q <= bus.I_rf_rdataA;
                data_b_q <= bus.I_rf_rdataB;
                data_c_q <= bus.I_rf_rdataC;
                opcode_q <= head[EntW-1 -: 4];
                rd_q     <= head[4*RADR_W-1 -: RADR_W];
            end
        end
    end

    assign bus.O_ready       = (count_q != DepthVal);
    assign bus.O_rf_radrA    = (state_q == StRead) ? head[3*RADR_W-1 -: RADR_W] : '0;
    assign bus.O_rf_radrB    = (state_q == StRead) ? head[2*RADR_W-1 -: RADR_W] : '0;
    assign bus.O_rf_radrC    = (state_q == StRead) ? head[RADR_W-1:0] : '0;
    // Register 0 is hard-wired zero, so its write-back is suppressed.
    assign bus.O_rf_we       = (state_q == StWb) && (rd_q != '0);
    assign bus.O_rf_wadr     = (state_q == StWb) ? rd_q : '0;
    assign bus.O_rf_wdata    = (state_q == StWb) ? result_q : '0;
    assign bus.O_core_dataA  = data_a_q;
    assign bus.O_core_dataB  = data_b_q;
    assign bus.O_core_dataC  = data_c_q;
    assign bus.O_core_opcode = opcode_q;
    assign bus.O_core_ctrl   = (state_q == StIssue);
    assign bus.O_busy        = (state_q != StIdle) || (count_q != '0);
    assign bus.O_err         = err_q;

`ifdef CORE_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (state_q == StIssue) perf_issued_q <= perf_issued_q + 32'd1;
            if (state_q == StWait)  perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign O_perf_issued = perf_issued_q;
    assign O_perf_stall  = perf_stall_q;
`endif
endmodule
